// File: rtl/fpnew_divsqrt_multi_fsm.sv
// Start/kill/register-enable control for a multi-cycle div/sqrt unit with one in-flight operation.
// Elastic valid/ready input and output pipelines; flush clears everything and kills a busy unit.
module fpnew_divsqrt_multi_fsm #(
  parameter int unsigned NumPipeRegs = 0,
  parameter logic [1:0]  PipeConfig  = 2'd1,
  parameter int unsigned TagWidth    = 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          in_valid_i,
  output logic                                          in_ready_o,
  input  logic [TagWidth-1:0]                           tag_i,
  input  logic                                          flush_i,
  output logic                                          out_valid_o,
  input  logic                                          out_ready_i,
  output logic [TagWidth-1:0]                           tag_o,
  output logic                                          busy_o,
  output logic [((NumPipeRegs > 0) ? NumPipeRegs : 1)-1:0] reg_enable_o,
  output logic                                          fsm_start_o,
  output logic                                          fsm_kill_o,
  input  logic                                          fsm_ready_i
);

  localparam logic [1:0] BEFORE      = 2'd0;
  localparam logic [1:0] AFTER       = 2'd1;
  localparam logic [1:0] INSIDE      = 2'd2;
  localparam logic [1:0] DISTRIBUTED = 2'd3;

  localparam int unsigned NUM_INP_REGS = (PipeConfig == BEFORE)      ? NumPipeRegs :
                                         (PipeConfig == DISTRIBUTED) ? NumPipeRegs / 2 : 0;
  localparam int unsigned NUM_OUT_REGS = (PipeConfig == AFTER || PipeConfig == INSIDE) ? NumPipeRegs :
                                         (PipeConfig == DISTRIBUTED) ? (NumPipeRegs + 1) / 2 : 0;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e                state_q, state_d;
  logic                  first_q;
  logic [TagWidth-1:0]   tag_q;
  logic                  head_vld, head_rdy, start;
  logic [TagWidth-1:0]   head_tag;
  logic                  res_vld, res_rdy;
  logic                  inp_busy, out_busy;

  // ---------------- input pipeline ----------------
  assign head_rdy = (state_q == IDLE) & fsm_ready_i;

  if (NUM_INP_REGS > 0) begin : g_inp
    logic                vq  [NUM_INP_REGS];
    logic [TagWidth-1:0] tq  [NUM_INP_REGS];
    logic                v   [NUM_INP_REGS];
    logic [TagWidth-1:0] t   [NUM_INP_REGS];
    logic                rdy [NUM_INP_REGS+1];
    logic [NUM_INP_REGS-1:0] en;

    always_comb begin
      rdy[NUM_INP_REGS] = head_rdy;
      for (int i = int'(NUM_INP_REGS) - 1; i >= 0; i--) rdy[i] = rdy[i+1] | ~vq[i];
    end

    always_comb begin
      en       = '0;
      inp_busy = 1'b0;
      v[0]     = in_valid_i;
      t[0]     = tag_i;
      for (int i = 1; i < int'(NUM_INP_REGS); i++) begin
        v[i] = vq[i-1];
        t[i] = tq[i-1];
      end
      for (int i = 0; i < int'(NUM_INP_REGS); i++) begin
        en[i]    = v[i] & rdy[i] & ~flush_i;
        inp_busy = inp_busy | vq[i];
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(NUM_INP_REGS); i++) begin
          vq[i] <= 1'b0;
          tq[i] <= '0;
        end
      end else begin
        for (int i = 0; i < int'(NUM_INP_REGS); i++) begin
          if (flush_i)     vq[i] <= 1'b0;
          else if (rdy[i]) vq[i] <= v[i];
          if (en[i])       tq[i] <= t[i];
        end
      end
    end

    assign head_vld   = vq[NUM_INP_REGS-1];
    assign head_tag   = tq[NUM_INP_REGS-1];
    assign in_ready_o = rdy[0];
  end else begin : g_no_inp
    assign head_vld   = in_valid_i;
    assign head_tag   = tag_i;
    assign in_ready_o = head_rdy;
    assign inp_busy   = 1'b0;
  end

  // ---------------- unit control FSM ----------------
  assign start       = head_vld & head_rdy & ~flush_i;
  assign fsm_start_o = start;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= start;
      if (start) tag_q <= head_tag;
    end
  end

  // The unit's ready flag still reflects the previous operation in the first busy cycle.
  always_comb begin
    state_d    = state_q;
    res_vld    = 1'b0;
    fsm_kill_o = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: begin
        if (!first_q && fsm_ready_i) begin
          res_vld = 1'b1;
          state_d = res_rdy ? IDLE : HOLD;
        end
      end
      HOLD: begin
        res_vld = 1'b1;
        if (res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d    = IDLE;
      res_vld    = 1'b0;
      fsm_kill_o = (state_q != IDLE);
    end
  end

  // ---------------- output pipeline ----------------
  if (NUM_OUT_REGS > 0) begin : g_out
    logic                vq  [NUM_OUT_REGS];
    logic [TagWidth-1:0] tq  [NUM_OUT_REGS];
    logic                v   [NUM_OUT_REGS];
    logic [TagWidth-1:0] t   [NUM_OUT_REGS];
    logic                rdy [NUM_OUT_REGS+1];
    logic [NUM_OUT_REGS-1:0] en;

    always_comb begin
      rdy[NUM_OUT_REGS] = out_ready_i;
      for (int i = int'(NUM_OUT_REGS) - 1; i >= 0; i--) rdy[i] = rdy[i+1] | ~vq[i];
    end

    always_comb begin
      en       = '0;
      out_busy = 1'b0;
      v[0]     = res_vld;
      t[0]     = tag_q;
      for (int i = 1; i < int'(NUM_OUT_REGS); i++) begin
        v[i] = vq[i-1];
        t[i] = tq[i-1];
      end
      for (int i = 0; i < int'(NUM_OUT_REGS); i++) begin
        en[i]    = v[i] & rdy[i] & ~flush_i;
        out_busy = out_busy | vq[i];
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(NUM_OUT_REGS); i++) begin
          vq[i] <= 1'b0;
          tq[i] <= '0;
        end
      end else begin
        for (int i = 0; i < int'(NUM_OUT_REGS); i++) begin
          if (flush_i)     vq[i] <= 1'b0;
          else if (rdy[i]) vq[i] <= v[i];
          if (en[i])       tq[i] <= t[i];
        end
      end
    end

    assign res_rdy     = rdy[0];
    assign out_valid_o = vq[NUM_OUT_REGS-1];
    assign tag_o       = tq[NUM_OUT_REGS-1];
  end else begin : g_no_out
    assign res_rdy     = out_ready_i;
    assign out_valid_o = res_vld;
    assign tag_o       = tag_q;
    assign out_busy    = 1'b0;
  end

  // ---------------- enables and status ----------------
  if (NumPipeRegs == 0) begin : g_en_none
    assign reg_enable_o = 1'b0;
  end else if (NUM_INP_REGS == 0) begin : g_en_out
    assign reg_enable_o = g_out.en;
  end else if (NUM_OUT_REGS == 0) begin : g_en_inp
    assign reg_enable_o = g_inp.en;
  end else begin : g_en_both
    assign reg_enable_o = {g_out.en, g_inp.en};
  end

  assign busy_o = inp_busy | out_busy | (state_q != IDLE);

endmodule
